// File: rtl/mcu_spi_target.sv
// -----------------------------------------------------------------------------
// mcu_spi_target
//
// SPI target (mode 0, CPOL=0/CPHA=0) bridging the MCU SPI link to the core's
// byte-command bus. MOSI is deserialised MSB first into bytes. Each byte is
// presented on data_rx with a single-cycle data_strobe. data_start flags the
// first byte of every frame. The decoder's response byte (data_tx) is
// serialised back on MISO, MSB first.
//
// Ports:
//   clk          system clock, at least 16x the SCLK frequency
//   reset_n      asynchronous active-low reset
//   spi_csn      chip select, active low, asynchronous to clk
//   spi_sclk     SPI clock, idles low, asynchronous to clk
//   spi_mosi     serial data from the MCU, MSB first
//   spi_miso     serial data to the MCU, MSB first
//   data_strobe  one-cycle pulse: data_rx holds a complete byte
//   data_start   high with data_strobe on the first byte of a frame
//   data_rx      last received byte; held between strobes
//   data_tx      response byte from the decoder, stable by strobe+1
//   frame_active synchronised CSn-low indication
//   timeout_err  sticky frame-abort flag, cleared at the next CSn fall
//
// Build option:
//   MCU_SPI_TIMEOUT_EN  adds an idle watchdog (parameter TIMEOUT_CYCLES). A
//                       frame that sees no SCLK edge for TIMEOUT_CYCLES clk
//                       cycles while CSn is low is aborted. Without the macro
//                       timeout_err is tied low.
// -----------------------------------------------------------------------------
module mcu_spi_target
`ifdef MCU_SPI_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
)
`endif
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_strobe,
    output logic       data_start,
    output logic [7:0] data_rx,
    input  logic [7:0] data_tx,
    output logic       frame_active,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Synchroniser chains. Index [1] is the synchronised level; index [2] is
    // the extra stage used only for edge detection.
    logic [2:0] csn_sync;
    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync;

    logic       csn_fall;
    logic       csn_rise;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       mosi_bit;
    logic       timeout_hit;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;       // first seven bits of the current byte
    logic [7:0] tx_byte;
    logic       start_pend;
    logic       strobe_d1;

    // CSn resets high so that releasing reset while the pin is idle cannot
    // look like a falling edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csn_sync  <= 3'b111;
            sclk_sync <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            csn_sync  <= {csn_sync[1:0], spi_csn};
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign csn_fall  =  csn_sync[2]  & ~csn_sync[1];
    assign csn_rise  = ~csn_sync[2]  &  csn_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
    assign mosi_bit  =  mosi_sync[1];

`ifdef MCU_SPI_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_cnt;
    logic        timeout_flag;

    assign timeout_hit = (state == ACTIVE) && (idle_cnt == TIMEOUT_LIMIT);

    // The idle counter only runs inside an active frame and restarts on
    // every synchronised SCLK edge; entering ACTIVE always starts it at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if ((state == ACTIVE) && !sclk_rise && !sclk_fall && !timeout_hit)
                idle_cnt <= idle_cnt + 16'd1;
            else
                idle_cnt <= '0;

            if ((state == IDLE) && csn_fall)
                timeout_flag <= 1'b0;
            else if (timeout_hit && !csn_rise)
                timeout_flag <= 1'b1;
        end
    end

    assign timeout_err = timeout_flag;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. A CSn rise takes priority over everything else in a
    // frame, including a byte-completing SCLK rise in the same cycle.
    // NOTE: state_next gets its default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (csn_fall)
                    state_next = ACTIVE;
            end
            ACTIVE: begin
                if (csn_rise)
                    state_next = IDLE;
                else if (timeout_hit)
                    state_next = ABORT;
            end
            ABORT: begin
                if (csn_rise)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shift register, bit counter, byte strobe and MISO driver.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_byte      <= '0;
            start_pend   <= 1'b0;
            strobe_d1    <= 1'b0;
            spi_miso     <= 1'b0;
            data_strobe  <= 1'b0;
            data_start   <= 1'b0;
            data_rx      <= '0;
            frame_active <= 1'b0;
        end else begin
            data_strobe <= 1'b0;
            data_start  <= 1'b0;
            strobe_d1   <= data_strobe;

            // The decoder updates data_tx one cycle after the strobe, so
            // the next response byte is captured two cycles after it.
            if (strobe_d1)
                tx_byte <= data_tx;

            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        start_pend   <= 1'b1;
                        tx_byte      <= data_tx;
                        spi_miso     <= data_tx[7];
                        frame_active <= 1'b1;
                        // An SCLK rise seen together with the CSn fall is
                        // bit 0 of the frame.
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[5:0], mosi_bit};
                            bit_cnt  <= 3'd1;
                        end else begin
                            bit_cnt  <= 3'd0;
                        end
                    end
                end

                ACTIVE: begin
                    if (csn_rise) begin
                        bit_cnt      <= '0;
                        spi_miso     <= 1'b0;
                        frame_active <= 1'b0;
                        start_pend   <= 1'b0;
                    end else if (timeout_hit) begin
                        bit_cnt  <= '0;
                        spi_miso <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[5:0], mosi_bit};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_rx     <= {rx_shift, mosi_bit};
                                data_strobe <= 1'b1;
                                data_start  <= start_pend;
                                start_pend  <= 1'b0;
                            end
                        end
                        // After a byte wraps bit_cnt to 0 this drives bit 7
                        // of the freshly reloaded response byte.
                        if (sclk_fall)
                            spi_miso <= tx_byte[3'd7 - bit_cnt];
                    end
                end

                ABORT: begin
                    spi_miso <= 1'b0;
                    if (csn_rise) begin
                        bit_cnt      <= '0;
                        frame_active <= 1'b0;
                        start_pend   <= 1'b0;
                    end
                end

                default: begin
                    spi_miso <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_spi_target.sv
// -----------------------------------------------------------------------------
// tb_mcu_spi_target
//
// Directed bench for mcu_spi_target. An SPI master task drives mode-0 bytes
// with 8-clk half periods. A negedge monitor logs every strobe. A small
// decoder model drives data_tx from a per-frame response table indexed by
// the number of strobes seen since the frame began.
// Define MCU_SPI_TIMEOUT_EN to build the timeout variant (TIMEOUT_CYCLES=100).
// -----------------------------------------------------------------------------
module tb_mcu_spi_target;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       spi_csn  = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       data_strobe;
    logic       data_start;
    logic [7:0] data_rx;
    logic [7:0] data_tx;
    logic       frame_active;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Strobe log, written only by the monitor.
    int         cyc           = 0;
    int         last_rise_cyc = 0;
    int         rx_total      = 0;
    logic [7:0] rx_byte  [64];
    logic       rx_start [64];
    logic       prev_strobe   = 1'b0;
    logic       dbl_strobe    = 1'b0;
    int         max_lat       = 0;

    // Decoder model: entry 0 is presented at CSn fall, entry n after strobe n.
    logic [7:0] dec_table [8];
    int         dec_base = 0;
    int         dec_off;

    assign dec_off = rx_total - dec_base;
    assign data_tx = dec_table[dec_off[2:0]];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_strobe) begin
            rx_byte[rx_total[5:0]]  = data_rx;
            rx_start[rx_total[5:0]] = data_start;
            rx_total = rx_total + 1;
            if (cyc - last_rise_cyc > max_lat)
                max_lat = cyc - last_rise_cyc;
            if (prev_strobe)
                dbl_strobe = 1'b1;
        end
        prev_strobe = data_strobe;
    end

`ifdef MCU_SPI_TIMEOUT_EN
    mcu_spi_target #(.TIMEOUT_CYCLES(100)) dut (
`else
    mcu_spi_target dut (
`endif
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_csn      (spi_csn),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .data_strobe  (data_strobe),
        .data_start   (data_start),
        .data_rx      (data_rx),
        .data_tx      (data_tx),
        .frame_active (frame_active),
        .timeout_err  (timeout_err)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Mode-0 master: MOSI set during SCLK low, MISO sampled just before the
    // rising edge. Sends nbits bits starting from mo[7].
    task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            repeat (8) @(negedge clk);
            mi[i] = spi_miso;
            spi_sclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (8) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        int base;
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            spi_csn  = 1'($urandom_range(0, 1));
            spi_sclk = 1'($urandom_range(0, 1));
            spi_mosi = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({spi_miso, data_strobe, data_start, data_rx, frame_active, timeout_err} !== 13'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: outputs %b required all zero", i,
                         {spi_miso, data_strobe, data_start, data_rx, frame_active, timeout_err});
            end
        end
        spi_csn  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        base    = rx_total;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (rx_total - base !== 0) begin
            errors++;
            $display("FAIL reset_release_strobes: got %0d required 0", rx_total - base);
        end
        checks++;
        if ({frame_active, spi_miso, data_rx} !== 10'd0) begin
            errors++;
            $display("FAIL reset_release_outputs: got %b required all zero", {frame_active, spi_miso, data_rx});
        end
    endtask

    task automatic test_status_frame();
        logic [7:0] resp [4];
        logic [7:0] mi   [4];
        int base;
        resp[0] = 8'hA5; resp[1] = 8'h5C; resp[2] = 8'h42; resp[3] = 8'h03;
        for (int i = 0; i < 8; i++) dec_table[i] = (i < 4) ? resp[i] : 8'h00;
        base     = rx_total;
        dec_base = rx_total;
        spi_csn  = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (frame_active !== 1'b1 || spi_miso !== 1'b1) begin
            errors++;
            $display("FAIL status_frame_open: frame_active=%b miso=%b required 1 1", frame_active, spi_miso);
        end
        for (int b = 0; b < 4; b++) spi_byte(8'h00, 8, mi[b]);
        repeat (8) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_total - base !== 4) begin
            errors++;
            $display("FAIL status_strobe_count: got %0d required 4", rx_total - base);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rx_byte[6'(base + b)] !== 8'h00 || rx_start[6'(base + b)] !== (b == 0)) begin
                errors++;
                $display("FAIL status_rx[%0d]: got %h start %b required 00 start %b", b,
                         rx_byte[6'(base + b)], rx_start[6'(base + b)], (b == 0));
            end
            checks++;
            if (mi[b] !== resp[b]) begin
                errors++;
                $display("FAIL status_miso[%0d]: got %h required %h", b, mi[b], resp[b]);
            end
        end
    endtask

    task automatic test_config_frame();
        logic [7:0] mosi_v [3];
        logic [7:0] mi;
        int base;
        int n;
        mosi_v[0] = 8'h04; mosi_v[1] = 8'h52; mosi_v[2] = 8'h01;
        base     = rx_total;
        dec_base = rx_total;
        spi_csn  = 1'b0;
        for (int b = 0; b < 3; b++) spi_byte(mosi_v[b], 8, mi);
        repeat (4) @(negedge clk);
        checks++;
        if (rx_total - base !== 3) begin
            errors++;
            $display("FAIL config_strobe_count: got %0d required 3", rx_total - base);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (rx_byte[6'(base + b)] !== mosi_v[b] || rx_start[6'(base + b)] !== (b == 0)) begin
                errors++;
                $display("FAIL config_rx[%0d]: got %h start %b required %h start %b", b,
                         rx_byte[6'(base + b)], rx_start[6'(base + b)], mosi_v[b], (b == 0));
            end
        end
        checks++;
        if (frame_active !== 1'b1) begin
            errors++;
            $display("FAIL config_active: got %b required 1", frame_active);
        end
        spi_csn = 1'b1;
        n = 0;
        while (frame_active === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_active !== 1'b0 || n > 4) begin
            errors++;
            $display("FAIL config_frame_end: frame_active=%b after %0d clk required 0 within 4", frame_active, n);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (data_rx !== 8'h01) begin
            errors++;
            $display("FAIL config_rx_hold: got %h required 01", data_rx);
        end
    endtask

    task automatic test_truncated();
        logic [7:0] mi;
        int base;
        base    = rx_total;
        spi_csn = 1'b0;
        spi_byte(8'hFF, 5, mi);
        spi_csn = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (rx_total - base !== 0) begin
            errors++;
            $display("FAIL truncated_no_strobe: got %0d strobes required 0", rx_total - base);
        end
        spi_csn = 1'b0;
        spi_byte(8'h01, 8, mi);
        spi_byte(8'h03, 8, mi);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_total - base !== 2 ||
            rx_byte[6'(base)] !== 8'h01 || rx_start[6'(base)] !== 1'b1 ||
            rx_byte[6'(base + 1)] !== 8'h03 || rx_start[6'(base + 1)] !== 1'b0) begin
            errors++;
            $display("FAIL truncated_next: count %0d bytes %h/%b %h/%b required 2 01/1 03/0",
                     rx_total - base, rx_byte[6'(base)], rx_start[6'(base)],
                     rx_byte[6'(base + 1)], rx_start[6'(base + 1)]);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] mi;
        int base;
        spi_csn = 1'b0;
        spi_byte(8'hE0, 3, mi);
        checks++;
        if (frame_active !== 1'b1) begin
            errors++;
            $display("FAIL midreset_before: frame_active %b required 1", frame_active);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({spi_miso, data_strobe, data_start, data_rx, frame_active, timeout_err} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_clear: outputs %b required all zero",
                     {spi_miso, data_strobe, data_start, data_rx, frame_active, timeout_err});
        end
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        base    = rx_total;
        spi_csn = 1'b0;
        spi_byte(8'h7E, 8, mi);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_total - base !== 1 || rx_byte[6'(base)] !== 8'h7E || rx_start[6'(base)] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_next: count %0d byte %h start %b required 1 7E 1",
                     rx_total - base, rx_byte[6'(base)], rx_start[6'(base)]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        int base;
        base    = rx_total;
        spi_csn = 1'b0;
        spi_byte(8'hAA, 8, mi);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(negedge clk);
        spi_csn = 1'b0;
        spi_byte(8'h55, 8, mi);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_total - base !== 2 ||
            rx_byte[6'(base)] !== 8'hAA || rx_start[6'(base)] !== 1'b1 ||
            rx_byte[6'(base + 1)] !== 8'h55 || rx_start[6'(base + 1)] !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: count %0d bytes %h/%b %h/%b required 2 AA/1 55/1",
                     rx_total - base, rx_byte[6'(base)], rx_start[6'(base)],
                     rx_byte[6'(base + 1)], rx_start[6'(base + 1)]);
        end
    endtask

`ifdef MCU_SPI_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] mi;
        int base;
        base    = rx_total;
        spi_csn = 1'b0;
        spi_byte(8'hF0, 4, mi);
        repeat (90) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b required 0", timeout_err);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: got %b required 1", timeout_err);
        end
        spi_byte(8'hFF, 8, mi);
        repeat (8) @(negedge clk);
        checks++;
        if (rx_total - base !== 0 || mi !== 8'h00 || frame_active !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ignore: strobes %0d miso %h active %b required 0 00 1",
                     rx_total - base, mi, frame_active);
        end
        spi_csn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (frame_active !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_csn_rise: active %b err %b required 0 1", frame_active, timeout_err);
        end
        spi_csn = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b required 0", timeout_err);
        end
        spi_csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        logic [7:0] mi;
        int base;
        base    = rx_total;
        spi_csn = 1'b0;
        spi_byte(8'hA3, 4, mi);
        repeat (150) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || frame_active !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_idle: err %b active %b required 0 1", timeout_err, frame_active);
        end
        spi_byte(8'h30, 4, mi);
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_total - base !== 1 || rx_byte[6'(base)] !== 8'hA3 || rx_start[6'(base)] !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout_byte: count %0d byte %h start %b required 1 A3 1",
                     rx_total - base, rx_byte[6'(base)], rx_start[6'(base)]);
        end
    endtask
`endif

    task automatic test_strobe_timing();
        checks++;
        if (dbl_strobe !== 1'b0) begin
            errors++;
            $display("FAIL strobe_consecutive: got %b required 0", dbl_strobe);
        end
        checks++;
        if (max_lat < 1 || max_lat > 4) begin
            errors++;
            $display("FAIL strobe_latency: worst %0d clk required 1..4", max_lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dec_table[i] = 8'h00;
        for (int i = 0; i < 64; i++) begin
            rx_byte[i]  = 8'h00;
            rx_start[i] = 1'b0;
        end
        test_reset();
        test_status_frame();
        test_config_frame();
        test_truncated();
        test_reset_mid_byte();
        test_back_to_back();
`ifdef MCU_SPI_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_strobe_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
